// File: rtl/known_ch_pkg.sv
// Shared types for the known cluster-head table: entry layout, FSM states
// and the cluster-head ranking function.
package known_ch_pkg;

  localparam int KCH_W     = 16;
  localparam int KCH_AGE_W = 2;

  localparam logic [KCH_W-1:0] HOPS_INVALID = '1;

  typedef struct packed {
    logic                 valid;
    logic [KCH_W-1:0]     id;
    logic [KCH_W-1:0]     hops;
    logic [KCH_W-1:0]     qvalue;
    logic [KCH_AGE_W-1:0] age;
  } ch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    UPDATE,
    SELECT
  } kch_state_t;

  // Higher Q wins, then fewer hops, then lower ID.
  function automatic logic ch_better(
    input ch_entry_t a,
    input ch_entry_t b
  );
    if (a.qvalue != b.qvalue) return a.qvalue > b.qvalue;
    if (a.hops != b.hops) return a.hops < b.hops;
    return a.id < b.id;
  endfunction

endpackage

// File: rtl/known_ch_table_compare.sv
// Combinational ranking comparator: aBetter is set when entry a outranks b.
// Validity and age are qualified by the caller, not here.
module ch_compare
  import known_ch_pkg::*;
(
  input  ch_entry_t a,
  input  ch_entry_t b,
  output logic      aBetter
);

  logic unusedBits;
  assign unusedBits = ^{a.valid, a.age, b.valid, b.age};

  assign aBetter = ch_better(a, b);

endmodule

// File: rtl/known_ch_table.sv
// Table of learned cluster heads; publishes the best one as chosen CH.
// Define KCH_AGING_EN to make heartbeats age entries instead of clearing.
module known_ch_table
  import known_ch_pkg::*;
#(
  parameter int WORD_WIDTH = KCH_W,
  parameter int CH_DEPTH   = 4,
  parameter int AGE_LIMIT  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_KCH,
  input  logic                          HB_reset,
  input  logic [WORD_WIDTH-1:0]         my_ID,
  input  logic [WORD_WIDTH-1:0]         fCH_ID,
  input  logic [WORD_WIDTH-1:0]         fCH_Hops,
  input  logic [WORD_WIDTH-1:0]         fCH_QValue,
  output logic [WORD_WIDTH-1:0]         chosenCH,
  output logic [WORD_WIDTH-1:0]         hopsfromCH,
  output logic [WORD_WIDTH-1:0]         chosenQValue,
  output logic                          ch_valid,
  output logic [$clog2(CH_DEPTH+1)-1:0] ch_count,
  output logic                          busy
);

  localparam int IDX_W = $clog2(CH_DEPTH);
  localparam int CNT_W = $clog2(CH_DEPTH+1);

  kch_state_t state, stateNext;

  logic [IDX_W-1:0] idx, matchIdx, freeIdx;
  logic [IDX_W-1:0] worstIdx, bestIdx;
  logic [IDX_W-1:0] selIdx, wrIdx;
  logic matchFound, freeFound;
  logic worstFound, bestFound;

  logic [WORD_WIDTH-1:0] candId, candHops, candQ;

  logic [CH_DEPTH-1:0]   vld;
  logic [WORD_WIDTH-1:0] ids   [CH_DEPTH];
  logic [WORD_WIDTH-1:0] hopsT [CH_DEPTH];
  logic [WORD_WIDTH-1:0] qT    [CH_DEPTH];

`ifdef KCH_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT+1);
  logic [AGE_W-1:0] ages [CH_DEPTH];
`else
  localparam int unusedAgeLimit = AGE_LIMIT;
`endif

  ch_entry_t curEnt, worstEnt, bestEnt, candEnt;
  logic worstBeatsCur, curBeatsBest, candBeatsWorst;
  logic lastIdx, accept, takeCur, selFound, doWrite;
  logic [CNT_W-1:0] popCnt;

  assign busy    = (state != IDLE);
  assign lastIdx = (idx == IDX_W'(CH_DEPTH-1));
  assign accept  = en_KCH && (fCH_ID != my_ID)
                   && (fCH_Hops != HOPS_INVALID);

  always_comb begin
    curEnt   = '{valid: vld[idx], id: ids[idx],
                 hops: hopsT[idx], qvalue: qT[idx],
                 age: '0};
    worstEnt = '{valid: vld[worstIdx], id: ids[worstIdx],
                 hops: hopsT[worstIdx], qvalue: qT[worstIdx],
                 age: '0};
    bestEnt  = '{valid: vld[bestIdx], id: ids[bestIdx],
                 hops: hopsT[bestIdx], qvalue: qT[bestIdx],
                 age: '0};
    candEnt  = '{valid: 1'b1, id: candId,
                 hops: candHops, qvalue: candQ,
                 age: '0};
  end

  ch_compare uWorst (
    .a       (worstEnt),
    .b       (curEnt),
    .aBetter (worstBeatsCur)
  );

  ch_compare uBest (
    .a       (curEnt),
    .b       (bestEnt),
    .aBetter (curBeatsBest)
  );

  ch_compare uCand (
    .a       (candEnt),
    .b       (worstEnt),
    .aBetter (candBeatsWorst)
  );

  always_comb begin
    popCnt = '0;
    for (int i = 0; i < CH_DEPTH; i++)
      popCnt = popCnt + CNT_W'(vld[i]);
  end

  // The last SELECT cycle folds its own entry into the result.
  assign takeCur  = vld[idx] && (!bestFound || curBeatsBest);
  assign selFound = takeCur || bestFound;
  assign selIdx   = takeCur ? idx : bestIdx;

  assign doWrite = matchFound || freeFound || candBeatsWorst;
  assign wrIdx   = matchFound ? matchIdx :
                   freeFound  ? freeIdx  : worstIdx;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = LOOKUP;
      LOOKUP:  if (lastIdx) stateNext = UPDATE;
      UPDATE:  stateNext = SELECT;
      SELECT:  if (lastIdx) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
`ifdef KCH_AGING_EN
    if (HB_reset) stateNext = SELECT;
`else
    if (HB_reset) stateNext = IDLE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld          <= '0;
      idx          <= '0;
      matchFound   <= 1'b0;
      freeFound    <= 1'b0;
      worstFound   <= 1'b0;
      bestFound    <= 1'b0;
      chosenCH     <= '0;
      hopsfromCH   <= HOPS_INVALID;
      chosenQValue <= '0;
      ch_valid     <= 1'b0;
      ch_count     <= '0;
    end else if (HB_reset) begin
      idx       <= '0;
      bestFound <= 1'b0;
`ifdef KCH_AGING_EN
      for (int i = 0; i < CH_DEPTH; i++) begin
        if (vld[i]) begin
          if (int'(ages[i]) + 1 >= AGE_LIMIT)
            vld[i] <= 1'b0;
          else
            ages[i] <= ages[i] + 1'b1;
        end
      end
`else
      vld          <= '0;
      chosenCH     <= '0;
      hopsfromCH   <= HOPS_INVALID;
      chosenQValue <= '0;
      ch_valid     <= 1'b0;
      ch_count     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (en_KCH) begin
            candId     <= fCH_ID;
            candHops   <= fCH_Hops;
            candQ      <= fCH_QValue;
            idx        <= '0;
            matchFound <= 1'b0;
            freeFound  <= 1'b0;
            worstFound <= 1'b0;
          end
        end
        LOOKUP: begin
          if (vld[idx] && ids[idx] == candId && !matchFound) begin
            matchFound <= 1'b1;
            matchIdx   <= idx;
          end
          if (!vld[idx] && !freeFound) begin
            freeFound <= 1'b1;
            freeIdx   <= idx;
          end
          if (vld[idx] && (!worstFound || worstBeatsCur)) begin
            worstFound <= 1'b1;
            worstIdx   <= idx;
          end
          idx <= lastIdx ? '0 : idx + 1'b1;
        end
        UPDATE: begin
          if (doWrite) begin
            vld[wrIdx]   <= 1'b1;
            ids[wrIdx]   <= candId;
            hopsT[wrIdx] <= candHops;
            qT[wrIdx]    <= candQ;
`ifdef KCH_AGING_EN
            ages[wrIdx]  <= '0;
`endif
          end
          idx       <= '0;
          bestFound <= 1'b0;
        end
        SELECT: begin
          if (takeCur) begin
            bestFound <= 1'b1;
            bestIdx   <= idx;
          end
          if (lastIdx) begin
            ch_valid <= selFound;
            ch_count <= popCnt;
            if (selFound) begin
              chosenCH     <= ids[selIdx];
              hopsfromCH   <= hopsT[selIdx];
              chosenQValue <= qT[selIdx];
            end else begin
              chosenCH     <= '0;
              hopsfromCH   <= HOPS_INVALID;
              chosenQValue <= '0;
            end
          end
          idx <= lastIdx ? '0 : idx + 1'b1;
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_known_ch_table.sv
// Directed scoreboard bench for known_ch_table (CH_DEPTH = 4).
// Expected outputs are queued with each offer and popped when busy drops.
module tb_known_ch_table;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst, en_KCH, HB_reset;
  logic [W-1:0]  my_ID, fCH_ID, fCH_Hops, fCH_QValue;
  logic [W-1:0]  chosenCH, hopsfromCH, chosenQValue;
  logic          ch_valid, busy;
  logic [CW-1:0] ch_count;

  known_ch_table #(
    .WORD_WIDTH (W),
    .CH_DEPTH   (D),
    .AGE_LIMIT  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_KCH       (en_KCH),
    .HB_reset     (HB_reset),
    .my_ID        (my_ID),
    .fCH_ID       (fCH_ID),
    .fCH_Hops     (fCH_Hops),
    .fCH_QValue   (fCH_QValue),
    .chosenCH     (chosenCH),
    .hopsfromCH   (hopsfromCH),
    .chosenQValue (chosenQValue),
    .ch_valid     (ch_valid),
    .ch_count     (ch_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ch;
    logic [W-1:0] hops;
    logic [W-1:0] q;
    logic         v;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] id, input logic [W-1:0] h,
                       input logic [W-1:0] q);
    en_KCH     = 1'b1;
    fCH_ID     = id;
    fCH_Hops   = h;
    fCH_QValue = q;
    tick();
    en_KCH     = 1'b0;
  endtask

  task automatic hb();
    HB_reset = 1'b1;
    tick();
    HB_reset = 1'b0;
  endtask

  task automatic clearTable();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, W'(busy), '0);
  endtask

  task automatic expectOut(input logic [W-1:0] ch, input logic [W-1:0] h,
                           input logic [W-1:0] q, input logic v,
                           input int cnt);
    exp_t e;
    e.ch   = ch;
    e.hops = h;
    e.q    = q;
    e.v    = v;
    e.cnt  = W'(cnt);
    sb.push_back(e);
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ch"},    chosenCH,      e.ch);
      chk({tag, "_hops"},  hopsfromCH,    e.hops);
      chk({tag, "_q"},     chosenQValue,  e.q);
      chk({tag, "_valid"}, W'(ch_valid),  W'(e.v));
      chk({tag, "_count"}, W'(ch_count),  e.cnt);
    end
  endtask

  task automatic step(input string tag, input logic [W-1:0] id,
                      input logic [W-1:0] h, input logic [W-1:0] q,
                      input logic [W-1:0] eCh, input logic [W-1:0] eH,
                      input logic [W-1:0] eQ, input int eCnt);
    expectOut(eCh, eH, eQ, 1'b1, eCnt);
    offer(id, h, q);
    waitIdle(tag);
    popCheck(tag);
  endtask

  task automatic checkCleared(input string tag);
    chk({tag, "_busy"}, W'(busy), '0);
    expectOut('0, 16'hFFFF, '0, 1'b0, 0);
    popCheck(tag);
  endtask

  initial begin
    rst        = 1'b1;
    en_KCH     = 1'b0;
    HB_reset   = 1'b0;
    my_ID      = 16'd100;
    fCH_ID     = '0;
    fCH_Hops   = '0;
    fCH_QValue = '0;
    tick();
    tick();
    checkCleared("rst");
    rst = 1'b0;
    hb();
    waitIdle("hb0");

    expectOut(16'd23, 16'd2, 16'h3000, 1'b1, 1);
    offer(16'd23, 16'd2, 16'h3000);
    chk("lat_busy", W'(busy), W'(1));
    repeat (8) tick();
    chk("lat_hold_ch", chosenCH, '0);
    chk("lat_hold_busy", W'(busy), W'(1));
    tick();
    chk("lat_done", W'(busy), '0);
    popCheck("t1a");
    step("t1b", 16'd45, 16'd2, 16'h2000,
         16'd23, 16'd2, 16'h3000, 2);

    step("t2a", 16'd6, 16'd1, 16'h4000,
         16'd6, 16'd1, 16'h4000, 3);
    my_ID = 16'd12;
    offer(16'd12, 16'd1, 16'h6000);
    chk("self_busy0", W'(busy), '0);
    repeat (3) tick();
    chk("self_busy1", W'(busy), '0);
    offer(16'd30, 16'hFFFF, 16'h7000);
    chk("badhops_busy", W'(busy), '0);
    repeat (10) tick();
    expectOut(16'd6, 16'd1, 16'h4000, 1'b1, 3);
    popCheck("reject");
    my_ID = 16'd100;

`ifndef KCH_AGING_EN
    hb();
    checkCleared("hbclr");
`endif
    clearTable();
    step("tie1a", 16'd9, 16'd1, 16'h4000,
         16'd9, 16'd1, 16'h4000, 1);
    step("tie1b", 16'd6, 16'd1, 16'h4000,
         16'd6, 16'd1, 16'h4000, 2);
    clearTable();
    step("tie2a", 16'd7, 16'd2, 16'h4000,
         16'd7, 16'd2, 16'h4000, 1);
    step("tie2b", 16'd8, 16'd1, 16'h4000,
         16'd8, 16'd1, 16'h4000, 2);

    clearTable();
    step("fill1", 16'd60, 16'd3, 16'h1000,
         16'd60, 16'd3, 16'h1000, 1);
    step("fill2", 16'd61, 16'd3, 16'h2000,
         16'd61, 16'd3, 16'h2000, 2);
    step("fill3", 16'd62, 16'd3, 16'h3000,
         16'd62, 16'd3, 16'h3000, 3);
    step("fill4", 16'd63, 16'd3, 16'h3800,
         16'd63, 16'd3, 16'h3800, 4);
    step("drop", 16'd50, 16'd1, 16'h0800,
         16'd63, 16'd3, 16'h3800, 4);
    step("repl", 16'd51, 16'd1, 16'h2800,
         16'd63, 16'd3, 16'h3800, 4);
    step("lower63", 16'd63, 16'd3, 16'h0100,
         16'd62, 16'd3, 16'h3000, 4);
    step("lower62", 16'd62, 16'd3, 16'h0100,
         16'd51, 16'd1, 16'h2800, 4);

    clearTable();
    step("ref1", 16'd6, 16'd1, 16'h4000,
         16'd6, 16'd1, 16'h4000, 1);
    step("ref2", 16'd23, 16'd2, 16'h3000,
         16'd6, 16'd1, 16'h4000, 2);
    expectOut(16'd23, 16'd2, 16'h3000, 1'b1, 2);
    offer(16'd6, 16'd1, 16'h1000);
    tick();
    tick();
    offer(16'd99, 16'd0, 16'h7FFF);
    chk("busy_ign", W'(busy), W'(1));
    waitIdle("ref3");
    popCheck("ref3");
    tick();
    chk("no_queue", W'(busy), '0);

    clearTable();
    step("ab1", 16'd77, 16'd1, 16'h2000,
         16'd77, 16'd1, 16'h2000, 1);
    offer(16'd78, 16'd2, 16'h1000);
    repeat (6) tick();
    chk("ab_in_sel", W'(busy), W'(1));
    hb();
`ifndef KCH_AGING_EN
    checkCleared("hbsel");
`else
    waitIdle("age1");
    expectOut(16'd77, 16'd1, 16'h2000, 1'b1, 2);
    popCheck("age1");
    hb();
    waitIdle("age2");
    expectOut(16'd77, 16'd1, 16'h2000, 1'b1, 2);
    popCheck("age2");
    hb();
    waitIdle("age3");
    checkCleared("age3");
`endif

    clearTable();
    step("mid1", 16'd5, 16'd1, 16'h0100,
         16'd5, 16'd1, 16'h0100, 1);
    offer(16'd88, 16'd1, 16'h7000);
    repeat (3) tick();
    clearTable();
    checkCleared("midrst");
    step("mid2", 16'd9, 16'd2, 16'h0200,
         16'd9, 16'd2, 16'h0200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/known_ch_table.md
Name: known_ch_table

Overview:
- Parametrised successor to the single-best known-cluster-head register.
- Holds a table of up to CH_DEPTH cluster heads learned from CH-exchange packets. Each entry stores ID, hop count and Q-value.
- Publishes the best entry as the node's chosen CH.
- Sits between the packet parser (which supplies fCH_* and en_KCH) and the routing/Q-learning logic (which consumes chosenCH, hopsfromCH and chosenQValue).

Parameters:
- WORD_WIDTH, 16, width of ID, hops and Q-value fields (Q-value unsigned Q2.14, 16'h4000 = 1.0).
- CH_DEPTH, 4, number of table entries (>=2).
- AGE_LIMIT, 3, heartbeats an entry survives without refresh (used only with KCH_AGING_EN).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; synchronous, active-high.
- en_KCH, in, 1, one-cycle strobe: fCH_* are valid.
- HB_reset, in, 1, heartbeat received; starts a new round.
- my_ID, in, WORD_WIDTH, this node's ID; matching entries are rejected.
- fCH_ID, in, WORD_WIDTH, candidate CH ID.
- fCH_Hops, in, WORD_WIDTH, candidate hop count; all-ones means invalid.
- fCH_QValue, in, WORD_WIDTH, candidate Q-value.
- chosenCH, out, WORD_WIDTH, ID of best entry.
- hopsfromCH, out, WORD_WIDTH, hops of best entry.
- chosenQValue, out, WORD_WIDTH, Q-value of best entry.
- ch_valid, out, 1, at least one valid entry exists.
- ch_count, out, $clog2(CH_DEPTH+1), number of valid entries.
- busy, out, 1, FSM not idle; en_KCH is dropped while high.

Behaviour:

Reset values (rst, clocked):
- All entries invalid.
- chosenCH = 0, hopsfromCH = all-ones, chosenQValue = 0.
- ch_valid = 0, ch_count = 0, busy = 0.

Ranking ("better"):
- Higher Q-value wins.
- On equal Q-value, fewer hops wins.
- On equal Q-value and hops, lower ID wins.
- All comparisons are unsigned.

FSM states: IDLE, LOOKUP, UPDATE, SELECT.

IDLE:
- On en_KCH, latch fCH_* into candidate registers.
- If fCH_ID == my_ID or fCH_Hops is all-ones, discard and stay in IDLE.
- Otherwise go to LOOKUP; busy = 1.

LOOKUP (CH_DEPTH cycles, one entry per cycle, index counter 0..CH_DEPTH-1):
- Record the first entry whose ID matches the candidate.
- Record the first free slot.
- Record the index of the worst valid entry.

UPDATE (1 cycle):
- ID match found: overwrite that entry's hops and Q-value (refresh, even if the new values are worse).
- Else free slot found: write the candidate there; ch_count increments.
- Else table full: replace the worst entry only if the candidate is better; otherwise drop it.

SELECT (CH_DEPTH cycles, sequential scan for the best valid entry):
- On the last scan cycle, register chosenCH, hopsfromCH, chosenQValue and ch_valid.
- Return to IDLE; busy = 0.

Latency:
- en_KCH to updated outputs: 2*CH_DEPTH+2 cycles, i.e. 10 for CH_DEPTH = 4.
- Outputs hold their previous values until then (no glitching mid-scan).

HB_reset:
- Without the optional feature, clears all entries and returns outputs to their reset values next cycle.
- Overrides any state: aborts LOOKUP/UPDATE/SELECT and goes to IDLE.
- If asserted in the same cycle as en_KCH, HB_reset wins and the candidate is dropped.

en_KCH while busy = 1: ignored, no queueing. The upstream parser must wait for busy = 0.

rst mid-operation: same as the reset state, with no partial write.

ch_count saturates at CH_DEPTH.

Optional Feature:

Macro: KCH_AGING_EN.

Defined:
- Each entry carries an age counter of $clog2(AGE_LIMIT+1) bits. A written or refreshed entry has age 0.
- HB_reset does not clear the table. It increments every valid entry's age and invalidates entries reaching AGE_LIMIT, decrementing ch_count accordingly.
- After the increment, the FSM runs SELECT so outputs reflect the surviving entries.
- HB_reset during busy aborts the operation, then performs the age step.

Undefined:
- HB_reset is a full clear as described above.
- No age storage is instantiated.

Decomposition:

Package known_ch_pkg:
- ch_entry_t struct {valid, id, hops, qvalue, age}.
- kch_state_t enum {IDLE, LOOKUP, UPDATE, SELECT}.
- Constant HOPS_INVALID = all-ones.
- Function ch_better(a, b) implementing the ranking.

Sub-module ch_compare: the combinational "better" comparator, instantiated by both the LOOKUP worst-tracker and the SELECT best-tracker.

Test Plan:
1. rst, HB_reset; then en_KCH with ID 23/hops 2/Q 16'h3000, then 45/2/16'h2000 -> after 10 cycles each: chosenCH = 23, hopsfromCH = 2, chosenQValue = 16'h3000, ch_count = 2.
2. Add 6/1/16'h4000 -> chosenCH = 6, hopsfromCH = 1, ch_count = 3. Then my_ID = 12 and offer 12/1/16'h6000 -> rejected, outputs unchanged, busy never asserts.
3. Tie-break: entries 9/1/16'h4000 and 6/1/16'h4000 -> chosenCH = 6. Entries 7/2/16'h4000 and 8/1/16'h4000 -> chosenCH = 8.
4. Fill 4 entries (Q 16'h1000, 16'h2000, 16'h3000, 16'h3800), then offer 50/1/16'h0800 -> dropped. Then offer 51/1/16'h2800 -> replaces the 16'h1000 entry; ch_count stays 4.
5. Refresh: re-send ID 6 with Q 16'h1000 -> entry updated, best re-selected, ch_count unchanged. Assert en_KCH while busy -> ignored.
6. HB_reset during SELECT -> busy = 0 next cycle, outputs at reset values, ch_count = 0. With KCH_AGING_EN and AGE_LIMIT = 3: an unrefreshed entry survives 2 heartbeats and is gone after the 3rd.
